// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and constants for the two-requester "0110" scan controller.
// Holds the controller state encoding, detector state constants and the pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } ctrl_state_t;

  // Detector states: Sn means the last n bits matched the pattern prefix.
  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  localparam logic [3:0] PATTERN = 4'b0110;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Request/response bus of seq_scan_ctrl; rsp_first exists only with SEQ_FIRST_POS_EN.
// Handshake: a transfer happens on a rising clk edge where valid && ready; a
// producer holds valid and data stable until that edge, ready may depend on valid.
interface seq_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic [CNT_W-1:0] rsp_count;
  logic             rsp_ready;
`ifdef SEQ_FIRST_POS_EN
  logic [$clog2(WIDTH+1)-1:0] rsp_first;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count, rsp_first
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count, rsp_first
  );
`else
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_count
  );
`endif
endinterface

// File: rtl/seq_detect_0110.sv
// Overlapping Mealy detector for the serial pattern 0110, one bit per enabled cycle.
module seq_detect_0110
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_in,
  input  logic en,
  output logic match
);

  logic [1:0] st;
  logic [1:0] st_nxt;

  always_comb begin
    st_nxt = st;
    match  = 1'b0;
    if (en) begin
      case (st)
        S0: st_nxt = bit_in ? S0 : S1;
        S1: st_nxt = bit_in ? S2 : S1;
        S2: st_nxt = bit_in ? S3 : S1;
        default: begin
          // The closing 0 of a match is also the opening 0 of the next one.
          st_nxt = bit_in ? S0 : S1;
          match  = (bit_in == PATTERN[0]);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)     st <= S0;
    else if (clr) st <= S0;
    else          st <= st_nxt;
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Round-robin two-requester front end that serializes words MSB-first into the
// 0110 detector and returns the match count. SEQ_FIRST_POS_EN adds rsp_first.
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_scan_ctrl_if.slave bus,
  output logic        busy,
  output ctrl_state_t state_dbg
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  ctrl_state_t      state, state_nxt;
  logic             last;
  logic             gnt_id;
  logic             accept;
  logic [WIDTH-1:0] sreg;
  logic             id_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             det_match;

  assign gnt_id = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept         = 1'b1;
          bus.req0_ready = ~gnt_id;
          bus.req1_ready = gnt_id;
          state_nxt      = ST_SHIFT;
        end
      end
      ST_SHIFT: if (idx_q == LAST_IDX) state_nxt = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  seq_detect_0110 u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .bit_in (sreg[WIDTH-1]),
    .en     (state == ST_SHIFT),
    .match  (det_match)
  );

`ifdef SEQ_FIRST_POS_EN
  localparam int FW = $clog2(WIDTH + 1);
  logic [FW-1:0] first_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      last  <= 1'b1;
      sreg  <= '0;
      id_q  <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
`ifdef SEQ_FIRST_POS_EN
      first_q <= '0;
`endif
    end else if (accept) begin
      sreg  <= gnt_id ? bus.req1_data : bus.req0_data;
      id_q  <= gnt_id;
      last  <= gnt_id;
      cnt_q <= '0;
      idx_q <= '0;
`ifdef SEQ_FIRST_POS_EN
      first_q <= FW'(WIDTH);
`endif
    end else if (state == ST_SHIFT) begin
      sreg  <= {sreg[WIDTH-2:0], 1'b0};
      idx_q <= idx_q + 1'b1;
      if (det_match && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
`ifdef SEQ_FIRST_POS_EN
      // Sentinel WIDTH marks an empty position; only the earliest hit is stored.
      if (det_match && (first_q == FW'(WIDTH))) first_q <= FW'(idx_q);
`endif
    end
  end

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_count = cnt_q;
`ifdef SEQ_FIRST_POS_EN
  assign bus.rsp_first = first_q;
`endif
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed scenarios plus randomized arbitration/words
// checked against a sliding-window pattern-count model. Honors SEQ_FIRST_POS_EN.
module tb_seq_scan_ctrl;
  import seq_pkg::*;

  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int FW  = $clog2(W + 1);
  localparam int EW  = 1 + CW + FW;
  localparam int W2  = 16;
  localparam int CW2 = 2;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_scan_ctrl_if #(.WIDTH(W),  .CNT_W(CW))  bus();
  seq_scan_ctrl_if #(.WIDTH(W2), .CNT_W(CW2)) bus16();
  logic        busy, busy16;
  ctrl_state_t st, st16;

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .state_dbg(st)
  );
  seq_scan_ctrl #(.WIDTH(W2), .CNT_W(CW2)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.slave), .busy(busy16), .state_dbg(st16)
  );

  int n_pass = 0;
  int n_total = 0;
  bit tb_last = 1'b1;
  logic [EW-1:0] exp_q[$];

  // Reference: count every 4-bit window equal to 0110, MSB-first, saturated.
  function automatic void ref_scan(input logic [31:0] d, input int w, input int cmax,
                                   output int cnt, output int first);
    cnt = 0;
    first = w;
    for (int i = 3; i < w; i++) begin
      if ({d[w-1-(i-3)], d[w-1-(i-2)], d[w-1-(i-1)], d[w-1-i]} == 4'b0110) begin
        if (first == w) first = i;
        cnt++;
      end
    end
    if (cnt > cmax) cnt = cmax;
  endfunction

  function automatic logic [EW-1:0] pack_exp(input bit id, input int cnt, input int first);
    return {id, CW'(cnt), FW'(first)};
  endfunction

  function automatic bit exp_gnt(input bit v0, input bit v1);
    return (v0 && v1) ? !tb_last : v1;
  endfunction

  // driver: present requests, wait for a grant, drop the granted valid after the edge
  task automatic do_accept(input bit v0, input bit v1, input logic [W-1:0] d0,
                           input logic [W-1:0] d1, output bit gid, output int t_acc);
    bit seen = 1'b0;
    gid = 1'b0;
    t_acc = -1;
    bus.req0_valid = v0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_data = d1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_total++;
    if (!seen) $display("FAIL accept_timeout: no ready within 40 cycles, required a grant");
    else n_pass++;
    if (seen) begin
      n_total++;
      if ((bus.req0_ready && bus.req1_ready) !== 1'b0)
        $display("FAIL ready_onehot: req0_ready=%b req1_ready=%b, required at most one",
                 bus.req0_ready, bus.req1_ready);
      else n_pass++;
      gid = bus.req1_ready;
      t_acc = cyc;
      @(posedge clk); #1;
      if (gid) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    end
  endtask

  // scoreboard: wait for the response, apply backpressure, compare with exp_q head
  task automatic sb_collect(input int t_acc, input int hold);
    bit seen = 1'b0;
    logic [EW-1:0] e;
    logic          cap_id;
    logic [CW-1:0] cap_cnt;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin seen = 1'b1; break; end
    end
    n_total++;
    if (!seen) begin
      $display("FAIL rsp_timeout: rsp_valid never rose, required within 60 cycles");
      return;
    end
    n_pass++;
    n_total++;
    if (cyc !== t_acc + W + 1)
      $display("FAIL rsp_latency: rsp_valid at cycle %0d, required %0d", cyc, t_acc + W + 1);
    else n_pass++;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_empty: response with no expected entry, required none");
      e = '0;
    end else begin
      n_pass++;
      e = exp_q.pop_front();
    end
    n_total++;
    if (bus.rsp_id !== e[EW-1]) $display("FAIL rsp_id: got %b, required %b", bus.rsp_id, e[EW-1]);
    else n_pass++;
    n_total++;
    if (bus.rsp_count !== e[FW+CW-1:FW])
      $display("FAIL rsp_count: got %0d, required %0d", bus.rsp_count, e[FW+CW-1:FW]);
    else n_pass++;
`ifdef SEQ_FIRST_POS_EN
    n_total++;
    if (bus.rsp_first !== e[FW-1:0])
      $display("FAIL rsp_first: got %0d, required %0d", bus.rsp_first, e[FW-1:0]);
    else n_pass++;
`endif
    cap_id = bus.rsp_id;
    cap_cnt = bus.rsp_count;
    for (int h = 0; h < hold; h++) begin
      n_total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req0_ready, bus.req1_ready, busy} !==
          {1'b1, cap_id, cap_cnt, 1'b0, 1'b0, 1'b1})
        $display("FAIL rsp_hold: valid=%b id=%b cnt=%0d r0=%b r1=%b busy=%b, required 1 %b %0d 0 0 1",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req0_ready, bus.req1_ready, busy,
                 cap_id, cap_cnt);
      else n_pass++;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, bus.rsp_valid} !== 2'b00)
      $display("FAIL post_rsp: busy=%b rsp_valid=%b, required 0 0", busy, bus.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_data = '0; bus.req1_data = '0;
    bus.rsp_ready = 0;
    bus16.req0_valid = 0; bus16.req1_valid = 0; bus16.req0_data = '0; bus16.req1_data = '0;
    bus16.rsp_ready = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req0_ready, bus.req1_ready, busy} !== '0)
      $display("FAIL reset_outputs: valid=%b id=%b cnt=%0d r0=%b r1=%b busy=%b, required all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req0_ready, bus.req1_ready, busy);
    else n_pass++;
    n_total++;
    if (st !== ST_IDLE) $display("FAIL reset_state: got %0d, required IDLE", st);
    else n_pass++;
    n_total++;
    if ({bus16.rsp_valid, bus16.rsp_count, busy16} !== '0)
      $display("FAIL reset16: valid=%b cnt=%0d busy=%b, required 0", bus16.rsp_valid,
               bus16.rsp_count, busy16);
    else n_pass++;
`ifdef SEQ_FIRST_POS_EN
    n_total++;
    if (bus.rsp_first !== '0) $display("FAIL reset_first: got %0d, required 0", bus.rsp_first);
    else n_pass++;
`endif
    rst = 1'b1;
    tb_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit g; int t;
    do_accept(1'b1, 1'b0, 8'b0110_1100, 8'h00, g, t);
    n_total++;
    if (g !== 1'b0) $display("FAIL single_gnt: got %b, required 0", g); else n_pass++;
    tb_last = g;
    exp_q.push_back(pack_exp(1'b0, 2, 3));
    @(negedge clk);
    n_total++;
    if ({busy, st} !== {1'b1, ST_SHIFT})
      $display("FAIL busy_rise: busy=%b st=%0d, required 1 SHIFT", busy, st);
    else n_pass++;
    sb_collect(t, 0);
  endtask

  task automatic test_no_match();
    bit g; int t;
    do_accept(1'b0, 1'b1, 8'h00, 8'hFF, g, t);
    n_total++;
    if (g !== 1'b1) $display("FAIL nomatch_gnt: got %b, required 1", g); else n_pass++;
    tb_last = g;
    exp_q.push_back(pack_exp(1'b1, 0, 8));
    sb_collect(t, 1);
  endtask

  task automatic test_tie();
    bit g; int t;
    rst = 1'b0; @(negedge clk); rst = 1'b1; tb_last = 1'b1;
    do_accept(1'b1, 1'b1, 8'b0110_1100, 8'b0110_0110, g, t);
    n_total++;
    if (g !== 1'b0) $display("FAIL tie_first: got %b, required 0", g); else n_pass++;
    tb_last = g;
    exp_q.push_back(pack_exp(1'b0, 2, 3));
    sb_collect(t, 0);
    do_accept(1'b0, 1'b1, 8'h00, 8'b0110_0110, g, t);
    n_total++;
    if (g !== 1'b1) $display("FAIL tie_second: got %b, required 1", g); else n_pass++;
    tb_last = g;
    exp_q.push_back(pack_exp(1'b1, 2, 3));
    sb_collect(t, 0);
    do_accept(1'b1, 1'b1, 8'h66, 8'h0F, g, t);
    n_total++;
    if (g !== 1'b0) $display("FAIL tie_third: got %b, required 0", g); else n_pass++;
    tb_last = g;
    exp_q.push_back(pack_exp(1'b0, 2, 3));
    sb_collect(t, 0);
    do_accept(1'b0, 1'b1, 8'h00, 8'h0F, g, t);
    tb_last = g;
    exp_q.push_back(pack_exp(1'b1, 0, 8));
    sb_collect(t, 0);
  endtask

  task automatic test_backpressure();
    bit g; int t; int c; int f;
    do_accept(1'b1, 1'b0, 8'b1011_0110, 8'h00, g, t);
    tb_last = g;
    ref_scan({24'd0, 8'b1011_0110}, W, 2**CW - 1, c, f);
    exp_q.push_back(pack_exp(g, c, f));
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    sb_collect(t, 5);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit g; int t;
    do_accept(1'b1, 1'b0, 8'b0110_0110, 8'h00, g, t);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req0_ready, bus.req1_ready, busy} !== '0)
      $display("FAIL midreset_outputs: valid=%b id=%b cnt=%0d busy=%b, required all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_count, busy);
    else n_pass++;
    n_total++;
    if (st !== ST_IDLE) $display("FAIL midreset_state: got %0d, required IDLE", st);
    else n_pass++;
    rst = 1'b1;
    tb_last = 1'b1;
    do_accept(1'b1, 1'b0, 8'b1011_0000, 8'h00, g, t);
    tb_last = g;
    exp_q.push_back(pack_exp(1'b0, 1, 4));
    sb_collect(t, 0);
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0, g, eg;
    logic [W-1:0] d0 = '0, d1 = '0;
    int t, c, f;
    for (int it = 0; it < 24; it++) begin
      if (!p0 && $urandom_range(0, 1)) begin p0 = 1; d0 = W'($urandom); end
      if (!p1 && $urandom_range(0, 1)) begin p1 = 1; d1 = W'($urandom); end
      if (!p0 && !p1) begin p0 = 1; d0 = W'($urandom); end
      eg = exp_gnt(p0, p1);
      do_accept(p0, p1, d0, d1, g, t);
      n_total++;
      if (g !== eg) $display("FAIL rand_gnt: iter %0d got %b, required %b", it, g, eg);
      else n_pass++;
      tb_last = g;
      ref_scan({24'd0, (g ? d1 : d0)}, W, 2**CW - 1, c, f);
      exp_q.push_back(pack_exp(g, c, f));
      if (g) p1 = 0; else p0 = 0;
      sb_collect(t, $urandom_range(0, 3));
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    bit seen = 1'b0; int t;
    bus16.req0_valid = 1'b1; bus16.req0_data = 16'b0110_1101_1011_0110;
    #1;
    n_total++;
    if (bus16.req0_ready !== 1'b1) $display("FAIL sat_ready: got %b, required 1", bus16.req0_ready);
    else n_pass++;
    t = cyc;
    @(posedge clk); #1;
    bus16.req0_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus16.rsp_valid) begin seen = 1'b1; break; end
    end
    n_total++;
    if (!seen || cyc !== t + W2 + 1)
      $display("FAIL sat_latency: seen=%b cycle %0d, required cycle %0d", seen, cyc, t + W2 + 1);
    else n_pass++;
    n_total++;
    if (bus16.rsp_count !== 2'd3) $display("FAIL sat_count: got %0d, required 3", bus16.rsp_count);
    else n_pass++;
`ifdef SEQ_FIRST_POS_EN
    n_total++;
    if (bus16.rsp_first !== 5'd3) $display("FAIL sat_first: got %0d, required 3", bus16.rsp_first);
    else n_pass++;
`endif
    bus16.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus16.rsp_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy16 !== 1'b0) $display("FAIL sat_idle: busy=%b, required 0", busy16);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_no_match();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d entries, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench exceeded time limit");
    $fatal(1);
  end

endmodule
